// File: rtl/trans_load_ctrl.sv
// AXI4 tile-set fetch sequencer: reads A, B and optionally C, streaming each beat into TRANS.
// Encodings: type 0=FP32 1=FP16 2=INT8 3=INT4; mat 0=A 1=B 2=C. Optional TRANS_LOAD_PERF_EN.
module trans_load_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        cfg_type_i,
  input  logic [1:0]        cfg_rc_i,
  input  logic              cfg_c_en_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] base_c_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [ID_W-1:0]   arid_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [255:0]      rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [255:0]      trans_data_o,
  output logic [4:0]        trans_burst_num_o,
  output logic [1:0]        trans_type_o,
  output logic [1:0]        trans_mat_o,
  output logic [1:0]        trans_rc_o,
  output logic              trans_valid_o
`ifdef TRANS_LOAD_PERF_EN
  ,
  output logic [31:0]       perf_busy_cyc_o,
  output logic [31:0]       perf_stall_cyc_o
`endif
);

  localparam logic [1:0] TypeFp32 = 2'd0;
  localparam logic [1:0] TypeInt4 = 2'd3;
  localparam logic [1:0] MatA     = 2'd0;
  localparam logic [1:0] MatB     = 2'd1;
  localparam logic [1:0] MatC     = 2'd2;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [4:0]        beat_q, beat_d;
  logic              over_q, over_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [1:0]        type_q, rc_q;
  logic              c_en_q;
  logic [ADDR_W-1:0] base_a_q, base_b_q, base_c_q;

  logic              tv_q;
  logic [255:0]      tdata_q;
  logic [4:0]        tburst_q;
  logic [1:0]        tmat_q, ttype_q, trc_q;

  logic              latch, load_beat, is_last;
  logic [5:0]        beats;
  logic [ADDR_W-1:0] cur_base;

  always_comb begin
    unique case (phase_q)
      MatA:    beats = (type_q == TypeFp32) ? 6'd16 : 6'd8;
      MatB:    beats = (type_q == TypeInt4) ? 6'd16 : 6'd8;
      default: beats = 6'd32;
    endcase
  end

  always_comb begin
    unique case (phase_q)
      MatA:    cur_base = base_a_q;
      MatB:    cur_base = base_b_q;
      default: cur_base = base_c_q;
    endcase
  end

  // over_q marks that the expected final beat has already gone by; later beats are dropped
  assign is_last = !over_q && ({1'b0, beat_q} == (beats - 6'd1));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    beat_d    = beat_q;
    over_d    = over_q;
    err_d     = err_q;
    done_d    = 1'b0;
    latch     = 1'b0;
    load_beat = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          latch   = 1'b1;
          phase_d = MatA;
          err_d   = (cfg_rc_i == 2'b11);
          state_d = (cfg_rc_i == 2'b11) ? StDone : StAddr;
        end
      end
      StAddr: begin
        if (arready_i) begin
          state_d = StData;
          beat_d  = '0;
          over_d  = 1'b0;
        end
      end
      StData: begin
        if (rvalid_i) begin
          load_beat = !over_q;
          if (beat_q != 5'd31) beat_d = beat_q + 5'd1;
          if (is_last) over_d = 1'b1;
          if ((rresp_i != 2'b00) || (rlast_i != is_last)) err_d = 1'b1;
          if (rlast_i) begin
            unique case (phase_q)
              MatA: begin
                phase_d = MatB;
                state_d = StAddr;
              end
              MatB: begin
                if (c_en_q) begin
                  phase_d = MatC;
                  state_d = StAddr;
                end else begin
                  state_d = StDone;
                end
              end
              default: state_d = StDone;
            endcase
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      phase_q  <= MatA;
      beat_q   <= '0;
      over_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      type_q   <= '0;
      rc_q     <= '0;
      c_en_q   <= 1'b0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      tv_q     <= 1'b0;
      tdata_q  <= '0;
      tburst_q <= '0;
      tmat_q   <= '0;
      ttype_q  <= '0;
      trc_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      beat_q  <= beat_d;
      over_q  <= over_d;
      err_q   <= err_d;
      done_q  <= done_d;
      tv_q    <= load_beat;
      if (latch) begin
        type_q   <= cfg_type_i;
        rc_q     <= cfg_rc_i;
        c_en_q   <= cfg_c_en_i;
        base_a_q <= base_a_i;
        base_b_q <= base_b_i;
        base_c_q <= base_c_i;
      end
      if (load_beat) begin
        tdata_q  <= rdata_i;
        tburst_q <= beat_q;
        tmat_q   <= phase_q;
        ttype_q  <= type_q;
        trc_q    <= rc_q;
      end
    end
  end

  assign busy_o            = (state_q != StIdle);
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign arvalid_o         = (state_q == StAddr);
  assign araddr_o          = arvalid_o ? cur_base : '0;
  assign arlen_o           = arvalid_o ? {2'b00, beats - 6'd1} : 8'd0;
  assign arsize_o          = arvalid_o ? 3'b101 : 3'b000;
  assign arburst_o         = arvalid_o ? 2'b01 : 2'b00;
  assign arid_o            = '0;
  assign rready_o          = (state_q == StData);
  assign trans_valid_o     = tv_q;
  assign trans_data_o      = tdata_q;
  assign trans_burst_num_o = tburst_q;
  assign trans_mat_o       = tmat_q;
  assign trans_type_o      = ttype_q;
  assign trans_rc_o        = trc_q;

`ifdef TRANS_LOAD_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;
  logic        stall;

  assign stall = (arvalid_o && !arready_i) || (rready_o && !rvalid_i);

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (latch) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy_o && !(&perf_busy_q)) perf_busy_d = perf_busy_q + 32'd1;
      if (stall && !(&perf_stall_q)) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cyc_o  = perf_busy_q;
  assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule

// File: doc/trans_load_ctrl.md
Name: trans_load_ctrl

Overview:
- Sequencer that fetches one tile set (A, then B, then optionally C) from memory over an AXI4 read channel.
- Streams every 256-bit beat into the TRANS layout/write-enable block together with burst_num, mat, data_type and rc.
- Sits between the command/CSR front end and TRANS; TRANS has no back-pressure, so this block alone owns the beat count and burst ordering.

Parameters:
- ADDR_W, 32, AXI address width
- ID_W, 4, AXI ID width; ARID driven constant 0

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; ignored while busy=1
- cfg_type  in  params::type_t  data type (FP32/FP16/INT8/INT4), latched on start
- cfg_rc  in  params::rc_t  B shape select (00 N8, 01, 10), latched on start
- cfg_c_en  in  1  fetch C after B, latched on start
- base_a / base_b / base_c  in  ADDR_W each  byte base addresses, 32-byte aligned, latched on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sequence end
- err  out  1  sticky; cleared on next accepted start
- araddr  out  ADDR_W  AXI read address
- arid  out  ID_W  AXI read ID (constant 0)
- arlen  out  8  AXI burst length
- arsize  out  3  AXI transfer size
- arburst  out  2  AXI burst type
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rdata  in  256  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI read valid
- rready  out  1  AXI read ready
- trans_data  out  256  to TRANS data_in
- trans_burst_num  out  5  to TRANS burst_num
- trans_type  out  params::type_t  to TRANS data_type
- trans_mat  out  params::mat_t  to TRANS mat
- trans_rc  out  params::rc_t  to TRANS rc
- trans_valid  out  1  to TRANS valid

Behaviour:
- Reset values: every output is 0, state is IDLE, counters are 0.
- Fixed AXI fields: arsize=3'b101 (32 B), arburst=INCR, arlen=beats-1.
- Beat count per phase:
  - A: FP32 16, FP16 8, INT8 8, INT4 8.
  - B: INT4 16, all other types 8, for any rc.
  - C: 32.
  - rc=11 with B: sets err at start; the sequence goes straight to DONE.
- States:
  - IDLE: on start, latch config and go to ADDR with phase=A.
  - ADDR: arvalid=1, araddr=base of the current phase. araddr/arlen stay stable until arready. On the arvalid&&arready cycle, go to DATA and clear the beat counter.
  - DATA: rready=1 continuously. Each rvalid beat increments the beat counter, width 5, saturating at 31. On the beat with rlast, phase A goes to ADDR with phase=B; phase B goes to ADDR with phase=C if cfg_c_en, else DONE; phase C goes to DONE.
  - DONE: done=1 for one cycle, busy=0, back to IDLE.
- TRANS interface:
  - Registered outputs: 1-cycle latency from the rvalid&&rready edge to trans_valid=1.
  - trans_data=rdata and trans_burst_num=beat index (0-based) for that beat.
  - trans_mat/type/rc are held for the whole phase.
  - trans_valid is 0 on all non-beat cycles, so no bubbles are inserted beyond AXI's own.
- Errors (err set, sequence continues; the burst is always drained to rlast):
  - rresp != OKAY on any beat.
  - rlast on a beat index != beats-1.
  - Beat index reaches beats without rlast: the extra beats are accepted with trans_valid=0.
- busy=1 in ADDR/DATA/DONE-entry. A start pulse while busy is dropped with no side effect.
- Only one outstanding AR at a time, never overlapping a data phase.
- Reset mid-operation: immediate return to IDLE with all outputs 0. arvalid deasserting under reset is permitted by AXI.

Optional Feature:
- Macro TRANS_LOAD_PERF_EN.
- Defined: adds outputs perf_busy_cyc[31:0] and perf_stall_cyc[31:0].
  - perf_busy_cyc counts cycles with busy=1.
  - perf_stall_cyc counts cycles in ADDR with !arready, plus cycles in DATA with !rvalid.
  - Both clear on accepted start and saturate at all-ones.
- Undefined: ports and logic absent; behaviour is otherwise identical.

Test Plan:
- FP16, rc=01, c_en=0, zero-wait slave:
  - 2 AR: base_a with arlen=7, then base_b with arlen=7.
  - 16 trans_valid pulses: burst_num 0..7 with mat=A, then 0..7 with mat=B.
  - done exactly 1 cycle after the last trans_valid; err=0.
- FP32, c_en=1:
  - arlen 15/7/31 for A/B/C.
  - 56 trans_valid pulses; last burst_num=31 with mat=C.
- INT4 rc=10, random rvalid/arready gaps (50%):
  - B phase yields burst_num 0..15 in order with no duplicates.
  - trans_valid count is exactly the rvalid&&rready count.
- rresp=SLVERR on A beat 3:
  - err=1, all 8 A beats still drained, B fetched, done pulses.
  - Next start clears err.
- Early rlast at A beat 5 (FP16): err=1, phase advances to B immediately.
- start held high during busy, then rst_n low mid-DATA:
  - Second start is ignored.
  - On reset, all outputs are 0 in the same cycle and state is IDLE.
  - A new start afterwards runs a clean sequence.
